axi4_lite_master: RTL

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master_if.sv | 33 +++
 rtl/axi4_lite_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the queued command master and its slave.
interface axi4_lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Command-queued AXI4-Lite master: FIFO of read/write commands, one AXI transaction at a time.
// Optional per-transaction watchdog enabled by defining AXI4L_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    output logic                rsp_we,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                busy,
    axi4_lite_master_if.master  m_axi
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + STRB_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("axi4_lite_master: DATA_W must be 32 or 64");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axi4_lite_master: FIFO_DEPTH must be a power of 2, at least 2");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("axi4_lite_master: TIMEOUT must be at least 1");
        end
    endgenerate

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_reg;
    logic [PTR_W:0]     rd_ptr_reg;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;
    logic [STRB_W-1:0]  head_wstrb;

    logic [1:0]         state_reg;
    logic [ADDR_W-1:0]  araddr_reg;
    logic               arvalid_reg;
    logic [ADDR_W-1:0]  awaddr_reg;
    logic               awvalid_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [STRB_W-1:0]  wstrb_reg;
    logic               wvalid_reg;
    logic               rsp_we_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic [1:0]         rsp_resp_reg;

    logic               bready_int;
    logic               rd_done;
    logic               wr_done;
    logic               timeout_hit;
    logic               timeout_fire;

    // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state_reg != IDLE);

    assign {head_we, head_addr, head_wdata, head_wstrb} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {cmd_we, cmd_addr, cmd_wdata, cmd_wstrb};
        end
    end

    // B channel is only accepted once both the address and data beats are gone.
    assign bready_int   = (state_reg == WR) && !awvalid_reg && !wvalid_reg;
    assign rd_done      = (state_reg == RD) && m_axi.rvalid;
    assign wr_done      = bready_int && m_axi.bvalid;
    assign timeout_fire = timeout_hit && !rd_done && !wr_done;

    assign m_axi.araddr  = araddr_reg;
    assign m_axi.arvalid = arvalid_reg;
    assign m_axi.rready  = (state_reg == RD);
    assign m_axi.awaddr  = awaddr_reg;
    assign m_axi.awvalid = awvalid_reg;
    assign m_axi.wdata   = wdata_reg;
    assign m_axi.wstrb   = wstrb_reg;
    assign m_axi.wvalid  = wvalid_reg;
    assign m_axi.bready  = bready_int;

    assign rsp_valid = (state_reg == DONE);
    assign rsp_we    = rsp_we_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

`ifdef AXI4L_MASTER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer_reg;
    logic             rsp_timeout_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_reg <= '0;
        end else if (state_reg == RD || state_reg == WR) begin
            timer_reg <= timer_reg + 1'b1;
        end else begin
            timer_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == RD || state_reg == WR) &&
                         (timer_reg == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_timeout_reg <= 1'b0;
        end else if (timeout_fire) begin
            rsp_timeout_reg <= 1'b1;
        end else if (rd_done || wr_done) begin
            rsp_timeout_reg <= 1'b0;
        end
    end

    assign rsp_timeout = rsp_timeout_reg;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            state_reg     <= IDLE;
            araddr_reg    <= '0;
            arvalid_reg   <= 1'b0;
            awaddr_reg    <= '0;
            awvalid_reg   <= 1'b0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            wvalid_reg    <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= 2'b00;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        if (head_we) begin
                            state_reg   <= WR;
                            awaddr_reg  <= head_addr;
                            wdata_reg   <= head_wdata;
                            wstrb_reg   <= head_wstrb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD;
                            araddr_reg  <= head_addr;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (m_axi.arready) arvalid_reg <= 1'b0;
                    if (rd_done) begin
                        state_reg     <= DONE;
                        arvalid_reg   <= 1'b0;
                        rsp_we_reg    <= 1'b0;
                        rsp_rdata_reg <= m_axi.rdata;
                        rsp_resp_reg  <= m_axi.rresp;
                    end else if (timeout_fire) begin
                        state_reg     <= DONE;
                        arvalid_reg   <= 1'b0;
                        rsp_we_reg    <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_resp_reg  <= 2'b10;
                    end
                end
                WR: begin
                    if (m_axi.awready) awvalid_reg <= 1'b0;
                    if (m_axi.wready)  wvalid_reg  <= 1'b0;
                    if (wr_done) begin
                        state_reg     <= DONE;
                        rsp_we_reg    <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rsp_resp_reg  <= m_axi.bresp;
                    end else if (timeout_fire) begin
                        state_reg     <= DONE;
                        awvalid_reg   <= 1'b0;
                        wvalid_reg    <= 1'b0;
                        rsp_we_reg    <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rsp_resp_reg  <= 2'b10;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
